// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register: captures forwarded operands and ID control for EX,
// inserts bubbles on stop/flush, freezes on hold, and counts inserted bubbles.
module id_ex_pipe_reg #(
   parameter int XLEN    = 32,
   parameter int ALUOP_W = 4,
   parameter int CNT_W   = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               stop,
   input  logic               flush,
   input  logic               hold,
   input  logic               ID_valid,
   input  logic [XLEN-1:0]    ID_pc,
   input  logic [XLEN-1:0]    ID_data1,
   input  logic [XLEN-1:0]    ID_data2,
   input  logic [XLEN-1:0]    ID_rD2,
   input  logic [XLEN-1:0]    ID_imm,
   input  logic [4:0]         ID_rd,
   input  logic               ID_we,
   input  logic               ID_load,
   input  logic               ID_store,
   input  logic               ID_branch,
   input  logic [ALUOP_W-1:0] ID_alu_op,
   input  logic [1:0]         ID_wd_sel,
   output logic               EX_valid,
   output logic [XLEN-1:0]    EX_pc,
   output logic [XLEN-1:0]    EX_data1,
   output logic [XLEN-1:0]    EX_data2,
   output logic [XLEN-1:0]    EX_rD2,
   output logic [XLEN-1:0]    EX_imm,
   output logic [4:0]         EX_rd,
   output logic               EX_we,
   output logic               EX_load,
   output logic               EX_store,
   output logic               EX_branch,
   output logic [ALUOP_W-1:0] EX_alu_op,
   output logic [1:0]         EX_wd_sel,
   output logic [CNT_W-1:0]   bubble_cnt,
   output logic [CNT_W-1:0]   flush_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic insert_bubble;
   assign insert_bubble = flush | stop;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         EX_valid  <= 1'b0;
         EX_pc     <= '0;
         EX_data1  <= '0;
         EX_data2  <= '0;
         EX_rD2    <= '0;
         EX_imm    <= '0;
         EX_rd     <= '0;
         EX_we     <= 1'b0;
         EX_load   <= 1'b0;
         EX_store  <= 1'b0;
         EX_branch <= 1'b0;
         EX_alu_op <= '0;
         EX_wd_sel <= '0;
      end else if (!hold) begin
         if (insert_bubble) begin
            EX_valid  <= 1'b0;
            EX_pc     <= '0;
            EX_data1  <= '0;
            EX_data2  <= '0;
            EX_rD2    <= '0;
            EX_imm    <= '0;
            EX_rd     <= '0;
            EX_we     <= 1'b0;
            EX_load   <= 1'b0;
            EX_store  <= 1'b0;
            EX_branch <= 1'b0;
            EX_alu_op <= '0;
            EX_wd_sel <= '0;
         end else begin
            // Invalid slots keep data but must never look like a writer to the hazard unit
            EX_valid  <= ID_valid;
            EX_pc     <= ID_pc;
            EX_data1  <= ID_data1;
            EX_data2  <= ID_data2;
            EX_rD2    <= ID_rD2;
            EX_imm    <= ID_imm;
            EX_rd     <= ID_valid ? ID_rd : 5'd0;
            EX_we     <= ID_valid & ID_we;
            EX_load   <= ID_valid & ID_load;
            EX_store  <= ID_valid & ID_store;
            EX_branch <= ID_valid & ID_branch;
            EX_alu_op <= ID_alu_op;
            EX_wd_sel <= ID_wd_sel;
         end
      end
   end

   // Flush wins attribution when both bubble sources are active
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bubble_cnt <= '0;
         flush_cnt  <= '0;
      end else if (!hold) begin
         if (flush) begin
            if (flush_cnt != CNT_MAX) flush_cnt <= flush_cnt + CNT_ONE;
         end else if (stop) begin
            if (bubble_cnt != CNT_MAX) bubble_cnt <= bubble_cnt + CNT_ONE;
         end
      end
   end

endmodule

// File: doc/id_ex_pipe_reg.md
Name: id_ex_pipe_reg

Overview:
ID/EX pipeline register directly downstream of the data-hazard/forwarding unit. It captures the forwarded operands (forward_data1, forward_data2, forward_rD2) and ID control each cycle and presents them to EX. It inserts a bubble on a load-use stop or a branch flush, and freezes on a global hold. Its EX_rd/EX_we/EX_load/EX_wd-source outputs feed back to the hazard unit. Two saturating counters record bubbles for performance debug.

Parameters:
XLEN, 32, datapath width
ALUOP_W, 4, ALU operation code width
CNT_W, 16, width of bubble/flush event counters

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
stop  in  1  load-use stall from the hazard unit; insert bubble into EX
flush  in  1  branch/jump taken in EX; squash the ID instruction
hold  in  1  global pipeline freeze (e.g. memory wait)
ID_valid  in  1  ID holds a real instruction
ID_pc  in  XLEN  PC of the ID instruction
ID_data1  in  XLEN  forwarded rs1 operand (hazard unit forward_data1)
ID_data2  in  XLEN  forwarded rs2 operand or immediate (forward_data2)
ID_rD2  in  XLEN  forwarded rs2 value for stores (forward_rD2)
ID_imm  in  XLEN  sign-extended immediate
ID_rd  in  5  destination register
ID_we  in  1  register-file write enable
ID_load  in  1  load instruction
ID_store  in  1  store instruction
ID_branch  in  1  conditional branch or jump
ID_alu_op  in  ALUOP_W  ALU operation
ID_wd_sel  in  2  writeback source select
EX_valid  out  1  EX holds a real instruction
EX_pc, EX_data1, EX_data2, EX_rD2, EX_imm  out  XLEN  registered copies
EX_rd  out  5  registered rd (to hazard unit)
EX_we, EX_load, EX_store, EX_branch  out  1  registered control
EX_alu_op  out  ALUOP_W  registered ALU op
EX_wd_sel  out  2  registered writeback select
bubble_cnt  out  CNT_W  count of load-use bubbles inserted
flush_cnt  out  CNT_W  count of flush bubbles inserted

Behaviour:
- All outputs are registered. No combinational path from any input to any output.
- Reset (rst_n=0, asynchronous): every output is 0, including both counters. This is a bubble state. Reset asserted mid-operation discards the EX contents immediately. The first capture happens on the first rising edge after rst_n rises.
- Per-edge priority: hold > flush > stop > normal capture.
- hold=1: every register, counters included, keeps its value, regardless of flush/stop. The upstream block keeps flush/stop asserted until hold drops.
- flush=1 (hold=0): load a bubble. Bubble: EX_valid, EX_we, EX_load, EX_store, EX_branch = 0; EX_rd = 0; EX_alu_op, EX_wd_sel = 0; all XLEN fields = 0. flush_cnt increments. When flush and stop are both asserted, only flush_cnt increments.
- stop=1 (hold=0, flush=0): load a bubble; bubble_cnt increments. The ID instruction is not lost: PC and IF/ID are frozen elsewhere, and the same instruction re-presents next cycle with corrected forwarded data.
- Normal: capture all ID_* fields and set EX_valid <= ID_valid.
  - If ID_valid=0, the control bits (we/load/store/branch) and EX_rd are forced to 0. Data fields are still captured.
- Counters saturate at all-ones and do not wrap. They reset only via rst_n.
- Latency: exactly one cycle from ID to EX when hold=0.
- A bubble never asserts EX_we or EX_load. The hazard unit therefore cannot see a false load-use or forwarding match from a bubble.

Test Plan:
- Reset: drive rst_n=0 asynchronously between edges with EX holding a valid load → all outputs are 0 immediately; after release with ID_valid=1, ID_rd=5, ID_we=1, ID_data1=0x1234 → next edge EX_rd=5, EX_we=1, EX_data1=0x00001234.
- Load-use: EX holds lw x5; ID add x6,x5,x1 with stop=1 for one cycle → next edge EX_valid=0, EX_we=0, EX_rd=0, bubble_cnt=1; following edge captures add with the forwarded ID_data1 value.
- Flush+stop together: flush=1, stop=1 → bubble, flush_cnt=1, bubble_cnt unchanged.
- Hold precedence: EX holds pc=0x100, then hold=1 with flush=1 for 3 cycles → EX_pc stays 0x100 and flush_cnt stays 0; hold drops while flush=1 → bubble, flush_cnt=1.
- Invalid capture: ID_valid=0, ID_we=1, ID_store=1, ID_rd=7 → EX_valid=0, EX_we=0, EX_store=0, EX_rd=0.
- Saturation: with CNT_W=4, assert stop for 20 cycles → bubble_cnt reaches 15 and stays at 15.
